// File: rtl/regfile_pkg.sv
// Shared register-file constants.
// Imported by the writeback arbiter slice.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [31:0] SP_INIT = 32'h7FC;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Secondary writer handshake bundle plus
// the register file write port.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int N_SEC = 2,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) ();
  logic [N_SEC-1:0] sec_valid;
  logic [N_SEC*ADDR_W-1:0] sec_reg;
  logic [N_SEC*DATA_W-1:0] sec_data;
  logic [N_SEC-1:0] sec_ready;
  logic rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output sec_valid, sec_reg, sec_data,
    input sec_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input sec_valid, sec_reg, sec_data,
    output sec_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or
// after ptr, wrapping, gets a one-hot grant.
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic found;

  always_comb begin
    gnt = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: pipeline vs
// secondary writers, starvation stall, busy board.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N_SEC = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_reg,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              stall_req,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_reg,
  output logic [31:0]       busy,
  regfile_wb_arbiter_if.slave wb
);
  localparam int PTR_W = (N_SEC > 1) ? $clog2(N_SEC) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STARVE_LIMIT - 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic pipe_win;
  logic sec_grant;
  logic denied;
  logic [N_SEC-1:0] req;
  logic [N_SEC-1:0] gnt;
  logic [PTR_W-1:0] g_idx;
  logic [ADDR_W-1:0] g_reg;
  logic [DATA_W-1:0] g_data;

  // Reset masks every grant so nothing commits.
  assign pipe_win = reset && pipe_we &&
                    (pipe_reg != '0);
  assign req = (reset && !pipe_win) ?
               wb.sec_valid : '0;

  rr_arbiter #(.N(N_SEC), .PW(PTR_W)) u_rr (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_SEC; i++) begin
      if (gnt[i]) g_idx = PTR_W'(i);
    end
  end

  assign g_reg = wb.sec_reg[g_idx*ADDR_W +: ADDR_W];
  assign g_data = wb.sec_data[g_idx*DATA_W +: DATA_W];
  assign sec_grant = |gnt;
  assign denied = (|wb.sec_valid) && !sec_grant;
  assign rr_nxt = (int'(g_idx) == N_SEC - 1) ?
                  '0 : g_idx + 1'b1;

  always_comb begin
    wb.rf_we = 1'b0;
    wb.rf_waddr = '0;
    wb.rf_wdata = '0;
    unique case (1'b1)
      pipe_win: begin
        wb.rf_we = 1'b1;
        wb.rf_waddr = pipe_reg;
        wb.rf_wdata = pipe_data;
      end
      sec_grant: begin
        wb.rf_we = (g_reg != '0);
        wb.rf_waddr = g_reg;
        wb.rf_wdata = g_data;
      end
      default: ;
    endcase
  end

  assign wb.sec_ready = gnt;

  // Set after clear so a same-cycle alloc wins.
  always_comb begin
    busy_nxt = busy_q;
    if (sec_grant) busy_nxt[g_reg] = 1'b0;
    if (alloc_valid) busy_nxt[alloc_reg] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
      wait_cnt <= '0;
      stall_req <= 1'b0;
      busy_q <= '0;
    end else begin
      stall_req <= 1'b0;
      busy_q <= busy_nxt;
      if (sec_grant) begin
        rr_ptr <= rr_nxt;
        wait_cnt <= '0;
      end else if (denied) begin
        if (wait_cnt == CNT_MAX) begin
          stall_req <= 1'b1;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter with
// a queue of expected write-port values.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic pipe_we;
  logic [4:0] pipe_reg;
  logic [31:0] pipe_data;
  logic stall_req;
  logic alloc_valid;
  logic [4:0] alloc_reg;
  logic [31:0] busy;
  int checks = 0;
  int errors = 0;
  int proto_err = 0;
  logic [39:0] exp_q[$];
  logic [39:0] e;
  logic [31:0] exp_busy;

  regfile_wb_arbiter_if #(
    .N_SEC(2), .ADDR_W(5), .DATA_W(32)
  ) bus ();

  regfile_wb_arbiter #(
    .N_SEC(2), .STARVE_LIMIT(8),
    .DATA_W(32), .ADDR_W(5)
  ) dut (
    .clk (clk),
    .reset (reset),
    .pipe_we (pipe_we),
    .pipe_reg (pipe_reg),
    .pipe_data (pipe_data),
    .stall_req (stall_req),
    .alloc_valid (alloc_valid),
    .alloc_reg (alloc_reg),
    .busy (busy),
    .wb (bus)
  );

  always #5 clk = ~clk;

  wire [39:0] wb_obs = {bus.rf_we, bus.rf_waddr,
                        bus.rf_wdata, bus.sec_ready};

  always @(negedge clk) begin
    if (reset === 1'b1 && stall_req === 1'b1 &&
        pipe_we === 1'b1) begin
      proto_err++;
      $display("FAIL protocol: pipe_we=1 during stall_req");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we = 1'b0;
    pipe_reg = '0;
    pipe_data = '0;
    alloc_valid = 1'b0;
    alloc_reg = '0;
    bus.sec_valid = '0;
  endtask

  task automatic sec_set(input logic [1:0] v,
                         input logic [4:0] r0,
                         input logic [4:0] r1,
                         input logic [31:0] d0,
                         input logic [31:0] d1);
    bus.sec_valid = v;
    bus.sec_reg = {r1, r0};
    bus.sec_data = {d1, d0};
  endtask

  task automatic pend(input logic we,
                      input logic [4:0] a,
                      input logic [31:0] d,
                      input logic [1:0] r);
    exp_q.push_back({we, a, d, r});
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pipe_we = 1'b1;
    pipe_reg = 5'd8;
    pipe_data = 32'h1234;
    alloc_valid = 1'b1;
    alloc_reg = 5'd5;
    sec_set(2'b11, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rf_we, bus.sec_ready} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs: got %b want 000",
                 {bus.rf_we, bus.sec_ready});
      end
      checks++;
      if (busy !== 32'h0) begin
        errors++;
        $display("FAIL reset_busy: got %h want 0", busy);
      end
      checks++;
      if (stall_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall: got %b want 0",
                 stall_req);
      end
      next_cycle();
    end
    reset = 1'b1;
    pipe_we = 1'b0;
    alloc_valid = 1'b0;
    pend(1'b1, 5'd3, 32'hAAAA, 2'b01);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (wb_obs !== e) begin
      errors++;
      $display("FAIL first_grant: got %h want %h",
               wb_obs, e);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    sec_set(2'b01, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rf_we, bus.sec_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_drop: got %b want 000",
               {bus.rf_we, bus.sec_ready});
    end
    next_cycle();
    reset = 1'b1;
    pend(1'b1, 5'd3, 32'hAAAA, 2'b01);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (wb_obs !== e) begin
      errors++;
      $display("FAIL reset_mid_retry: got %h want %h",
               wb_obs, e);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_pipe_priority();
    pipe_we = 1'b1;
    pipe_reg = 5'd8;
    pipe_data = 32'h1234;
    sec_set(2'b01, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB);
    pend(1'b1, 5'd8, 32'h1234, 2'b00);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (wb_obs !== e) begin
      errors++;
      $display("FAIL pipe_wins: got %h want %h",
               wb_obs, e);
    end
    next_cycle();
    checks++;
    if (dut.wait_cnt !== 3'd1) begin
      errors++;
      $display("FAIL pipe_wait_cnt: got %0d want 1",
               dut.wait_cnt);
    end
    pipe_reg = 5'd0;
    sec_set(2'b10, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB);
    pend(1'b1, 5'd4, 32'hBBBB, 2'b10);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (wb_obs !== e) begin
      errors++;
      $display("FAIL pipe_x0_dropped: got %h want %h",
               wb_obs, e);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_round_robin();
    sec_set(2'b11, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) pend(1'b1, 5'd3, 32'hAAAA, 2'b01);
      else pend(1'b1, 5'd4, 32'hBBBB, 2'b10);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (wb_obs !== e) begin
        errors++;
        $display("FAIL rr_alt[%0d]: got %h want %h",
                 i, wb_obs, e);
      end
      next_cycle();
    end
    sec_set(2'b10, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB);
    for (int i = 0; i < 3; i++) begin
      pend(1'b1, 5'd4, 32'hBBBB, 2'b10);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (wb_obs !== e) begin
        errors++;
        $display("FAIL rr_sec1_only[%0d]: got %h want %h",
                 i, wb_obs, e);
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_starvation();
    pipe_reg = 5'd9;
    pipe_data = 32'h5555;
    sec_set(2'b01, 5'd6, 5'd4, 32'hCCCC, 32'hBBBB);
    for (int c = 1; c <= 9; c++) begin
      pipe_we = (c != 9);
      if (c == 9) pend(1'b1, 5'd6, 32'hCCCC, 2'b01);
      else pend(1'b1, 5'd9, 32'h5555, 2'b00);
      @(negedge clk);
      checks++;
      if (stall_req !== (c == 9)) begin
        errors++;
        $display("FAIL stall_cycle[%0d]: got %b want %b",
                 c, stall_req, (c == 9));
      end
      e = exp_q.pop_front();
      checks++;
      if (wb_obs !== e) begin
        errors++;
        $display("FAIL starve_wb[%0d]: got %h want %h",
                 c, wb_obs, e);
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if (stall_req !== 1'b0 || dut.wait_cnt !== 3'd0) begin
      errors++;
      $display("FAIL stall_after: got %b/%0d want 0/0",
               stall_req, dut.wait_cnt);
    end
    next_cycle();
  endtask

  task automatic test_scoreboard();
    exp_busy = 32'h0;
    alloc_valid = 1'b1;
    alloc_reg = 5'd5;
    next_cycle();
    exp_busy[5] = 1'b1;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL sb_alloc: got %h want %h",
               busy, exp_busy);
    end
    alloc_valid = 1'b0;
    sec_set(2'b01, 5'd5, 5'd4, 32'hDDDD, 32'hBBBB);
    pend(1'b1, 5'd5, 32'hDDDD, 2'b01);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (wb_obs !== e) begin
      errors++;
      $display("FAIL sb_commit_wb: got %h want %h",
               wb_obs, e);
    end
    next_cycle();
    exp_busy[5] = 1'b0;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL sb_clear: got %h want %h",
               busy, exp_busy);
    end
    bus.sec_valid = 2'b00;
    alloc_valid = 1'b1;
    next_cycle();
    bus.sec_valid = 2'b01;
    next_cycle();
    exp_busy[5] = 1'b1;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL sb_set_wins: got %h want %h",
               busy, exp_busy);
    end
    alloc_valid = 1'b0;
    next_cycle();
    exp_busy[5] = 1'b0;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL sb_final_clear: got %h want %h",
               busy, exp_busy);
    end
    idle();
    next_cycle();
  endtask

  task automatic test_zero_reg();
    exp_busy = 32'h0;
    alloc_valid = 1'b1;
    alloc_reg = 5'd7;
    next_cycle();
    exp_busy[7] = 1'b1;
    alloc_valid = 1'b0;
    sec_set(2'b01, 5'd0, 5'd4, 32'hEEEE, 32'hBBBB);
    pend(1'b0, 5'd0, 32'hEEEE, 2'b01);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (wb_obs !== e) begin
      errors++;
      $display("FAIL x0_grant: got %h want %h",
               wb_obs, e);
    end
    next_cycle();
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL x0_busy: got %h want %h",
               busy, exp_busy);
    end
    idle();
    alloc_valid = 1'b1;
    alloc_reg = 5'd0;
    next_cycle();
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL x0_alloc: got %h want %h",
               busy, exp_busy);
    end
    idle();
    next_cycle();
  endtask

  initial begin
    idle();
    bus.sec_reg = '0;
    bus.sec_data = '0;
    test_reset();
    test_reset_mid();
    test_pipe_priority();
    test_round_robin();
    test_starvation();
    test_scoreboard();
    test_zero_reg();
    checks++;
    if (proto_err !== 0) begin
      errors++;
      $display("FAIL protocol_count: got %0d want 0",
               proto_err);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
